// File: rtl/csa_block_accum_if.sv
// csa_block_accum_if: operand-in / block-sum-out handshake bundle.
// Ports: in_valid/in_ready/in_a/in_b/in_c, out_valid/out_ready/out_sum/out_overflow.
interface csa_block_accum_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_overflow;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );
endinterface

// File: rtl/csa_block_accum.sv
// csa_block_accum: carry-save block accumulator, 3 operands/beat, BLOCK_LEN beats/block.
// Ports: clk, rst_n (async low), bus (slave handshake), busy. Option: CSA_BLOCK_ACCUM_SAT_EN.
module csa_block_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_block_accum_if.slave     bus,
  output logic                 busy
);
  localparam int IW = WIDTH + $clog2(3*BLOCK_LEN) + 1;
  localparam int CW = $clog2(BLOCK_LEN);

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    RESOLVE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            p1v_q;
  logic [IW-1:0]   ps_q, pc_q;
  logic [IW-1:0]   s_q, c_q;
  logic            out_valid_q;
  logic            out_ov_q;
  logic [ACC_W-1:0] out_sum_q;

  logic [IW-1:0]   ax, bx, cx;
  logic [IW-1:0]   ps_d, pc_d;
  logic [IW-1:0]   s_d, c_d;
  logic [IW-1:0]   t_s, t_c;
  logic [IW-1:0]   r;
  logic            res_ov;
  logic [ACC_W-1:0] res_sum;
  logic            accept;
  logic            last;
  logic            load;

  assign ax = IW'($signed(bus.in_a));
  assign bx = IW'($signed(bus.in_b));
  assign cx = IW'($signed(bus.in_c));

  assign bus.in_ready     = (state_q == ACCUM);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_overflow = out_ov_q;
  assign busy = (state_q != ACCUM) || (cnt_q != '0);

  assign accept = bus.in_valid && (state_q == ACCUM);
  assign last   = (cnt_q == CW'(BLOCK_LEN-1));
  // Output register busy with unaccepted data holds RESOLVE.
  assign load   = (state_q == RESOLVE) &&
                  !(out_valid_q && !bus.out_ready);
  assign r      = s_q + c_q;

  always_comb begin
    ps_d = ax ^ bx ^ cx;
    pc_d = ((ax & bx) | (ax & cx) | (bx & cx)) << 1;
    // 4:2 compressor as two chained full-adder rows.
    t_s  = s_q ^ c_q ^ ps_q;
    t_c  = ((s_q & c_q) | (s_q & ps_q) | (c_q & ps_q)) << 1;
    s_d  = t_s ^ t_c ^ pc_q;
    c_d  = ((t_s & t_c) | (t_s & pc_q) | (t_c & pc_q)) << 1;
  end

  generate
    if (ACC_W >= IW) begin : g_wide
      logic signed [IW-1:0] r_s;
      assign r_s     = r;
      assign res_ov  = 1'b0;
      assign res_sum = ACC_W'(r_s);
    end else begin : g_narrow
      logic [IW-ACC_W:0] hi;
      logic [ACC_W-1:0]  wrap;
      assign hi     = r[IW-1:ACC_W-1];
      assign wrap   = r[ACC_W-1:0];
      // Representable iff all dropped bits equal the new sign bit.
      assign res_ov = !((&hi) || !(|hi));
`ifdef CSA_BLOCK_ACCUM_SAT_EN
      localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
      localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
      assign res_sum = !res_ov ? wrap :
                       (r[IW-1] ? SMIN : SMAX);
`else
      assign res_sum = wrap;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      p1v_q       <= 1'b0;
      ps_q        <= '0;
      pc_q        <= '0;
      s_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_ov_q    <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      p1v_q <= accept;
      if (accept) begin
        ps_q <= ps_d;
        pc_q <= pc_d;
      end
      if (p1v_q) begin
        s_q <= s_d;
        c_q <= c_d;
      end
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (1'b1)
        (state_q == ACCUM): begin
          if (accept) begin
            if (last) begin
              cnt_q   <= '0;
              state_q <= FLUSH;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        (state_q == FLUSH): begin
          state_q <= RESOLVE;
        end
        (state_q == RESOLVE): begin
          if (load) begin
            out_sum_q   <= res_sum;
            out_ov_q    <= res_ov;
            out_valid_q <= 1'b1;
            s_q         <= '0;
            c_q         <= '0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end
endmodule
